acq_peak_search: RTL and testbench

ACQ_PEAK_SEARCH -- requirements
Module: acq_peak_search

---
 rtl/acq_peak_search_pkg.sv | 20 ++
 rtl/acq_peak_search_iq_magnitude.sv | 74 +++++++
 rtl/acq_peak_search.sv | 132 +++++++++++++
 tb/tb_acq_peak_search.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_peak_search_pkg.sv
// Shared constants and FSM state encoding for the acquisition peak search.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acq_peak_search_pkg;

   localparam int SAMPLES  = 10230;  // samples per dwell
   localparam int NUM_BINS = 2046;   // half-chip code-phase bins
   localparam int MAG_W    = 26;     // magnitude width
   localparam int BIN_W    = 11;     // bin index width

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_DWELL  = 3'd2,
      ST_EVAL   = 3'd3,
      ST_SLIP   = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

endpackage

// File: rtl/acq_peak_search_iq_magnitude.sv
// Centers the I/Q one-counts, takes absolute values, then squares and sums them.
// Latency: 2 register stages from in_vld to out_vld (the compare stage lives in the parent).
// Backpressure: none; a valid sample always flows through.
module iq_magnitude #(
   parameter int SAMPLES = 10230,
   parameter int MAG_W   = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   input  logic [13:0]      sum_sin,
   input  logic [13:0]      sum_cos,
   output logic             out_vld,
   output logic [MAG_W-1:0] mag
);

   localparam logic signed [14:0] HALF = 15'(SAMPLES / 2);

   logic signed [14:0] i_ctr;
   logic signed [14:0] q_ctr;
   logic [14:0]        i_abs;
   logic [14:0]        q_abs;
   logic [14:0]        i_abs_q;
   logic [14:0]        q_abs_q;
   logic               vld1_q;
   logic [MAG_W-1:0]   i_ext;
   logic [MAG_W-1:0]   q_ext;
   logic [MAG_W-1:0]   mag_d;
   logic [MAG_W-1:0]   mag_q;
   logic               vld2_q;

   // Stage 1 combinational: center around SAMPLES/2 and fold to magnitude
   always_comb begin
      i_ctr = $signed({1'b0, sum_sin}) - HALF;
      q_ctr = $signed({1'b0, sum_cos}) - HALF;
      i_abs = i_ctr[14] ? 15'(-i_ctr) : 15'(i_ctr);
      q_abs = q_ctr[14] ? 15'(-q_ctr) : 15'(q_ctr);
   end

   // Stage 1 registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_abs_q <= '0;
         q_abs_q <= '0;
         vld1_q  <= 1'b0;
      end else begin
         i_abs_q <= i_abs;
         q_abs_q <= q_abs;
         vld1_q  <= in_vld;
      end
   end

   // Stage 2 combinational: square and sum at full magnitude width
   always_comb begin
      i_ext = MAG_W'(i_abs_q);
      q_ext = MAG_W'(q_abs_q);
      mag_d = i_ext * i_ext + q_ext * q_ext;
   end

   // Stage 2 registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_q  <= '0;
         vld2_q <= 1'b0;
      end else begin
         mag_q  <= mag_d;
         vld2_q <= vld1_q;
      end
   end

   assign mag     = mag_q;
   assign out_vld = vld2_q;

endmodule

// File: rtl/acq_peak_search.sv
// Sweeps all code-phase bins, one dwell per bin, and keeps the strongest I/Q magnitude.
// Latency: magnitude compared 3 cycles after the accepted sum_ready edge; done one cycle after the last compare.
// Backpressure: none; sum_ready edges outside SETTLE/DWELL and starts while busy are dropped.
module acq_peak_search #(
   parameter int SAMPLES  = acq_peak_search_pkg::SAMPLES,
   parameter int NUM_BINS = acq_peak_search_pkg::NUM_BINS,
   parameter int MAG_W    = acq_peak_search_pkg::MAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [MAG_W-1:0] threshold,
   input  logic [13:0]      sum_sin,
   input  logic [13:0]      sum_cos,
   input  logic             sum_ready,
   output logic             code_slip,
   output logic             busy,
   output logic             done,
   output logic             detected,
   output logic [10:0]      best_bin,
   output logic [MAG_W-1:0] best_mag
);

   import acq_peak_search_pkg::*;

   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

   state_t           state_q;
   state_t           state_d;
   logic             sum_ready_q;
   logic             rdy_edge;
   logic             pipe_in_vld;
   logic             mag_vld;
   logic [MAG_W-1:0] mag;
   logic [BIN_W-1:0] bin_q;
   logic [BIN_W-1:0] best_bin_q;
   logic [MAG_W-1:0] best_mag_q;
   logic [MAG_W-1:0] thr_q;
   logic             detected_q;

   // A dwell is only the rising edge of sum_ready; a held level counts once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_ready_q <= 1'b0;
      end else begin
         sum_ready_q <= sum_ready;
      end
   end

   assign rdy_edge    = sum_ready & ~sum_ready_q;
   assign pipe_in_vld = (state_q == ST_DWELL) & rdy_edge;

   iq_magnitude #(
      .SAMPLES (SAMPLES),
      .MAG_W   (MAG_W)
   ) u_iq_magnitude (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (pipe_in_vld),
      .sum_sin (sum_sin),
      .sum_cos (sum_cos),
      .out_vld (mag_vld),
      .mag     (mag)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; the first dwell after start or a slip is stale and skipped
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SETTLE;
         ST_SETTLE: if (rdy_edge) state_d = ST_DWELL;
         ST_DWELL:  if (rdy_edge) state_d = ST_EVAL;
         ST_EVAL: begin
            if (mag_vld) begin
               state_d = (bin_q == LAST_BIN) ? ST_FINISH : ST_SLIP;
            end
         end
         ST_SLIP:   state_d = ST_SETTLE;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Sweep datapath: clear at start, strict-greater update keeps the lower bin on ties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q      <= '0;
         best_bin_q <= '0;
         best_mag_q <= '0;
         thr_q      <= '0;
         detected_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  bin_q      <= '0;
                  best_bin_q <= '0;
                  best_mag_q <= '0;
                  thr_q      <= threshold;
                  detected_q <= 1'b0;
               end
            end
            ST_EVAL: begin
               if (mag_vld && (mag > best_mag_q)) begin
                  best_mag_q <= mag;
                  best_bin_q <= bin_q;
               end
            end
            ST_SLIP:   bin_q <= bin_q + BIN_W'(1);
            ST_FINISH: detected_q <= (best_mag_q > thr_q);
            default: ;
         endcase
      end
   end

   assign code_slip = (state_q == ST_SLIP);
   assign done      = (state_q == ST_FINISH);
   assign busy      = (state_q != ST_IDLE);
   assign detected  = detected_q;
   assign best_bin  = best_bin_q;
   assign best_mag  = best_mag_q;

endmodule

// File: tb/tb_acq_peak_search.sv
// Self-checking bench for acq_peak_search with an 8-bin sweep.
// Latency: n/a.
// Backpressure: n/a.
module tb_acq_peak_search;

   localparam int NB  = 8;
   localparam int MW  = 26;
   localparam int MID = 5115;

   typedef struct packed {
      logic [NB-1:0][13:0] sin;
      logic [NB-1:0][13:0] cos;
      logic [MW-1:0]       thr;
      logic [10:0]         exp_bin;
      logic [MW-1:0]       exp_mag;
      logic                exp_det;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [MW-1:0] threshold = '0;
   logic [13:0]   sum_sin = '0;
   logic [13:0]   sum_cos = '0;
   logic          sum_ready = 1'b0;
   logic          code_slip;
   logic          busy;
   logic          done;
   logic          detected;
   logic [10:0]   best_bin;
   logic [MW-1:0] best_mag;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int slip_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;

   vec_t tbl[6];
   int   cyc_tbl[6];

   always #50 clk = ~clk;

   acq_peak_search #(.NUM_BINS(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .threshold (threshold),
      .sum_sin   (sum_sin),
      .sum_cos   (sum_cos),
      .sum_ready (sum_ready),
      .code_slip (code_slip),
      .busy      (busy),
      .done      (done),
      .detected  (detected),
      .best_bin  (best_bin),
      .best_mag  (best_mag)
   );

   // Count slip and done pulses away from the active edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (code_slip) slip_cnt = slip_cnt + 1;
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic check(input string nm, input longint act, input longint exp);
      tests = tests + 1;
      if (act != exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: magnitude per bin from the centered counts, first strict maximum wins
   task automatic ref_model(inout vec_t v);
      longint best;
      int     bb;
      best = 0;
      bb   = 0;
      for (int b = 0; b < NB; b++) begin
         longint di;
         longint dq;
         longint m;
         di = longint'(v.sin[b]) - MID;
         dq = longint'(v.cos[b]) - MID;
         m  = di * di + dq * dq;
         if (m > best) begin
            best = m;
            bb   = b;
         end
      end
      v.exp_mag = MW'(best);
      v.exp_bin = 11'(bb);
      v.exp_det = (best > longint'(v.thr));
   endtask

   task automatic give_dwell(input logic [13:0] s, input logic [13:0] c, input int len, input bit st);
      @(posedge clk);
      #1;
      sum_sin   = s;
      sum_cos   = c;
      sum_ready = 1'b1;
      start     = st;
      repeat (len) begin
         @(posedge clk);
         #1 start = 1'b0;
      end
      sum_ready = 1'b0;
      sum_sin   = 14'($urandom_range(0, 10230));
      sum_cos   = 14'($urandom_range(0, 10230));
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_bin(input int b, input int s0, input int d0);
      int k;
      k = 0;
      while ((slip_cnt - s0) <= b && done_cnt == d0 && k < 300) begin
         @(posedge clk);
         k = k + 1;
      end
      check("bin_wait_in_budget", (k < 300), 1);
   endtask

   task automatic run_sweep(input vec_t v, input int long_bin, input int restart_bin,
                            output int slips, output int dones, output int cycles);
      int s0;
      int d0;
      int t0;
      s0 = slip_cnt;
      d0 = done_cnt;
      threshold = v.thr;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      t0 = cyc;
      for (int b = 0; b < NB; b++) begin
         give_dwell(14'($urandom_range(0, 10230)), 14'($urandom_range(0, 10230)), 2, (b == restart_bin));
         give_dwell(v.sin[b], v.cos[b], (b == long_bin) ? 50 : 2, 1'b0);
         wait_bin(b, s0, d0);
      end
      repeat (10) @(posedge clk);
      slips  = slip_cnt - s0;
      dones  = done_cnt - d0;
      cycles = done_cyc - t0;
   endtask

   task automatic check_sweep(input string nm, input vec_t v, input int slips, input int dones);
      @(negedge clk);
      check({nm, "_best_bin"}, best_bin, v.exp_bin);
      check({nm, "_best_mag"}, best_mag, v.exp_mag);
      check({nm, "_detected"}, detected, v.exp_det);
      check({nm, "_slips"}, slips, NB - 1);
      check({nm, "_dones"}, dones, 1);
      check({nm, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      int slips;
      int dones;
      int cycles;
      int sc;
      int dc;

      // Directed vectors with hand-computed expectations
      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < NB; b++) begin
            tbl[i].sin[b] = 14'(MID);
            tbl[i].cos[b] = 14'(MID);
         end
      end
      tbl[0].sin[5] = 14'd6115;
      tbl[0].thr = 26'd500000;  tbl[0].exp_bin = 11'd5; tbl[0].exp_mag = 26'd1000000; tbl[0].exp_det = 1'b1;
      tbl[1].thr = 26'd500000;  tbl[1].exp_bin = 11'd0; tbl[1].exp_mag = 26'd0;       tbl[1].exp_det = 1'b0;
      tbl[2].sin[2] = 14'd5415; tbl[2].cos[2] = 14'd5415;
      tbl[2].sin[6] = 14'd5415; tbl[2].cos[6] = 14'd5415;
      tbl[2].thr = 26'd100000;  tbl[2].exp_bin = 11'd2; tbl[2].exp_mag = 26'd180000;  tbl[2].exp_det = 1'b1;
      // Random vectors scored by the reference model
      for (int i = 3; i < 6; i++) begin
         for (int b = 0; b < NB; b++) begin
            tbl[i].sin[b] = 14'($urandom_range(0, 10230));
            tbl[i].cos[b] = 14'($urandom_range(0, 10230));
         end
         tbl[i].thr = MW'($urandom_range(0, 40000000));
         ref_model(tbl[i]);
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_code_slip", code_slip, 0);
      check("rst_detected", detected, 0);
      check("rst_best_bin", best_bin, 0);
      check("rst_best_mag", best_mag, 0);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Table-driven sweeps
      for (int i = 0; i < 6; i++) begin
         run_sweep(tbl[i], -1, -1, slips, dones, cycles);
         cyc_tbl[i] = cycles;
         check_sweep($sformatf("vec%0d", i), tbl[i], slips, dones);
      end

      // sum_ready held high for 50 cycles on bin 3 counts as a single dwell
      run_sweep(tbl[0], 3, -1, slips, dones, cycles);
      check_sweep("long_hold", tbl[0], slips, dones);

      // A start issued mid-sweep changes neither result nor timing
      run_sweep(tbl[1], -1, 2, slips, dones, cycles);
      check_sweep("restart_ignored", tbl[1], slips, dones);
      check("restart_timing", cycles, cyc_tbl[1]);

      // Reset during bin 3 aborts the sweep
      sc = slip_cnt;
      dc = done_cnt;
      threshold = tbl[4].thr;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int b = 0; b < 3; b++) begin
         give_dwell(14'($urandom_range(0, 10230)), 14'($urandom_range(0, 10230)), 2, 1'b0);
         give_dwell(tbl[0].sin[b + 4], tbl[0].cos[b + 4], 2, 1'b0);
         wait_bin(b, sc, dc);
      end
      give_dwell(tbl[0].sin[5], tbl[0].cos[5], 2, 1'b0);
      @(negedge clk);
      check("pre_rst_busy", busy, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_code_slip", code_slip, 0);
      check("midrst_detected", detected, 0);
      check("midrst_best_bin", best_bin, 0);
      check("midrst_best_mag", best_mag, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      sc = slip_cnt;
      dc = done_cnt;
      repeat (20) @(posedge clk);
      check("post_rst_no_done", done_cnt - dc, 0);
      check("post_rst_no_slip", slip_cnt - sc, 0);
      run_sweep(tbl[4], -1, -1, slips, dones, cycles);
      check_sweep("after_reset", tbl[4], slips, dones);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
